alu_wb_stage: RTL
=================

# alu_wb_stage

Writeback and flag stage directly downstream of the GPU/DSP 32-bit ALU. Captures each ALU result (`aluq`, `alu_co`) with its destination register, updates the architectural Z/C/N flags in the accept cycle, and queues the result in a 2-entry buffer. The buffer drains to the shared register-file write port whenever that port is not claimed by a higher-priority external write (load data, external bus writes). Also provides a pending-write hazard check to the operand-fetch stage.

## Interface
- `DEPTH`, 2: writeback buffer entries (fixed at 2; other values unsupported)
- `sys_clk`  in  1  system clock, all state on rising edge
- `xreset`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result valid this cycle
- `alu_ready`  out  1  stage can accept a result this cycle
- `aluq`  in  32  ALU result
- `alu_co`  in  1  ALU carry/borrow out
- `alu_func`  in  3  ALU function code (0-3 add/sub, 4-6 logic, 7 conditional add/sub)
- `alu_dst`  in  5  destination register index
- `alu_wb`  in  1  result is written to the register file (0 = compare-style, flags only)
- `alu_flagwe`  in  1  instruction updates flags
- `flag_wr`  in  1  direct flag write from the control-register path
- `flag_din`  in  3  {N,C,Z} for `flag_wr`
- `flags`  out  3  {N,C,Z} architectural flags
- `ext_wr_req`  in  1  external writer owns the register-file port this cycle
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  5  write address
- `rf_wdata`  out  32  write data
- `haz_addr`  in  5  source register index to check
- `haz_hit`  out  1  `haz_addr` matches a valid buffered entry

## Operation
- Accept = `alu_valid & alu_ready`. `alu_ready` = buffer count < 2. Depends only on registered count, never on `ext_wr_req`.
- On accept with `alu_wb`=1: push {`alu_dst`, `aluq`} at the tail. With `alu_wb`=0: no push, flags only.
- Flag update on accept with `alu_flagwe`=1:
  - Z = (`aluq`==0); N = `aluq[31]`.
  - C = `alu_co` for `alu_func` 0-3 and 7.
  - C is unchanged for `alu_func` 4-6.
- `flag_wr` loads `flag_din` into all three flags. If it coincides with an ALU flag update, `flag_wr` wins.
- Drain: `rf_we` = head valid & ~`ext_wr_req`. `rf_waddr`/`rf_wdata` come from the head entry, driven from registers. Head pops on the same edge that `rf_we` is high.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- Two entries with the same `alu_dst` are written in order, so the later one wins.
- `haz_hit` = OR over valid entries of (entry addr == `haz_addr`). Combinational from registered state.
- When `ext_wr_req` is high, `rf_waddr`/`rf_wdata` are don't-care with `rf_we`=0.

## Timing
- Reset values: `flags`=000, buffer empty, `alu_ready`=1, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `haz_hit`=0.
- Latency:
  - Result accepted at edge t appears with `rf_we`=1 in cycle t..t+1 at the earliest (buffer empty, port free).
  - `flags` reflect it immediately after edge t.
- Full (count=2): `alu_ready`=0 even if a pop occurs that cycle. Upstream must stall one extra cycle; this is accepted, to keep `ext_wr_req` off the ready path.
- Empty: `rf_we`=0.
- `ext_wr_req` held high stalls draining indefinitely. Entries and `haz_hit` persist.
- Reset mid-operation: buffered entries are discarded without writing, flags clear, `rf_we` drops asynchronously.

## Structure
- Shared package holds:
  - ALU function-code constants: ADD, ADC, SUB, SBC, AND, OR, XOR, ADDQ_COND = 0..7.
  - Flag bit positions: Z=0, C=1, N=2.
  - Writeback entry struct: 5-bit addr + 32-bit data.
- One sub-module: `wb_fifo2`, a 2-entry synchronous FIFO with push/pop, count, and per-entry valid/addr exposure for the hazard compare.
- Flag logic and port arbitration stay in `alu_wb_stage`.

## Test plan
- Reset, then single ADD (`aluq`=0, `alu_co`=1, dst=5, flagwe=1) with port free -> next cycle `rf_we`=1, addr=5, data=0; `flags`=C|Z=011.
- AND (`alu_func`=4), `aluq`=0x8000_0000 with C previously 1 -> `flags`=N|C=110, C preserved.
- `ext_wr_req` held high, three back-to-back results to dst 1, 2, 3 -> first two accepted, `alu_ready`=0 on the third. Release -> writes 1, 2 in order, then 3 is accepted.
- Buffer holds dst=7, `haz_addr`=7 -> `haz_hit`=1. After it drains -> `haz_hit`=0.
- Same-cycle `flag_wr` (din=100) and ALU flag update (result 0) -> `flags`=100.
- Assert `xreset` with 2 entries buffered -> `rf_we`=0 immediately, no writes afterwards, `flags`=000, `alu_ready`=1.

Source files
------------

// File: rtl/alu_wb_stage_pkg.sv
// Shared definitions for the ALU writeback stage.
// Function codes, flag bit positions and the writeback entry layout.
package alu_wb_stage_pkg;

    localparam logic [2:0] ADD       = 3'd0;
    localparam logic [2:0] ADC       = 3'd1;
    localparam logic [2:0] SUB       = 3'd2;
    localparam logic [2:0] SBC       = 3'd3;
    localparam logic [2:0] AND       = 3'd4;
    localparam logic [2:0] OR        = 3'd5;
    localparam logic [2:0] XOR       = 3'd6;
    localparam logic [2:0] ADDQ_COND = 3'd7;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    // Logic ops leave the carry untouched.
    function automatic logic func_sets_carry(input logic [2:0] func);
        logic sets;
        sets = 1'b1;
        unique case (1'b1)
            (func == AND),
            (func == OR),
            (func == XOR): sets = 1'b0;
            default:       sets = 1'b1;
        endcase
        return sets;
    endfunction

endpackage

// File: rtl/alu_wb_stage_wb_fifo2.sv
// Two-entry writeback FIFO.
// Exposes every slot's valid/addr so the owner can do hazard compares.
module wb_fifo2
    import alu_wb_stage_pkg::*;
(
    input  logic            sys_clk,
    input  logic            xreset,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output wb_entry_t       head,
    output logic            head_valid,
    output logic [1:0]      count,
    output logic [1:0]      slot_valid,
    output logic [1:0][4:0] slot_addr
);

    wb_entry_t mem [2];
    logic      rd_ptr;
    logic      wr_ptr;
    logic      do_push;
    logic      do_pop;

    assign do_push = push & (count != 2'd2);
    assign do_pop  = pop & (count != 2'd0);

    always_ff @(posedge sys_clk or posedge xreset) begin
        if (xreset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (do_pop && !do_push) begin
                count <= count - 2'd1;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != 2'd0);

    always_comb begin
        slot_valid = '0;
        slot_addr  = '0;
        for (int i = 0; i < 2; i++) begin
            slot_valid[i] = (count == 2'd2)
                          | ((count == 2'd1) & (rd_ptr == 1'(i)));
            slot_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback/flag stage: flag update, 2-entry result buffer,
// register-file port arbitration and pending-write hazard check.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        sys_clk,
    input  logic        xreset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [31:0] aluq,
    input  logic        alu_co,
    input  logic [2:0]  alu_func,
    input  logic [4:0]  alu_dst,
    input  logic        alu_wb,
    input  logic        alu_flagwe,
    input  logic        flag_wr,
    input  logic [2:0]  flag_din,
    output logic [2:0]  flags,
    input  logic        ext_wr_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  haz_addr,
    output logic        haz_hit
);

    wb_entry_t       head;
    wb_entry_t       push_entry;
    logic            head_valid;
    logic [1:0]      count;
    logic [1:0]      slot_valid;
    logic [1:0][4:0] slot_addr;
    logic            accept;
    logic            push;
    logic [2:0]      flags_nxt;

    // Ready looks only at registered occupancy, so a pop in a full
    // cycle does not open the gate until the next cycle.
    assign alu_ready = (count != 2'(DEPTH));
    assign accept    = alu_valid & alu_ready;
    assign push      = accept & alu_wb;

    assign push_entry.addr = alu_dst;
    assign push_entry.data = aluq;

    wb_fifo2 u_fifo (
        .sys_clk    (sys_clk),
        .xreset     (xreset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (rf_we),
        .head       (head),
        .head_valid (head_valid),
        .count      (count),
        .slot_valid (slot_valid),
        .slot_addr  (slot_addr)
    );

    assign rf_we    = head_valid & ~ext_wr_req;
    assign rf_waddr = head.addr;
    assign rf_wdata = head.data;

    always_comb begin
        haz_hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (slot_valid[i] && (slot_addr[i] == haz_addr)) begin
                haz_hit = 1'b1;
            end
        end
    end

    always_comb begin
        flags_nxt = flags;
        if (flag_wr) begin
            flags_nxt = flag_din;
        end else if (accept && alu_flagwe) begin
            flags_nxt[FLAG_Z] = (aluq == 32'd0);
            flags_nxt[FLAG_N] = aluq[31];
            if (func_sets_carry(alu_func)) begin
                flags_nxt[FLAG_C] = alu_co;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge xreset) begin
        if (xreset) begin
            flags <= 3'b000;
        end else begin
            flags <= flags_nxt;
        end
    end

endmodule
